// File: rtl/xtop_pkg.sv
// Shared widths, opcodes and ROM image type for the picoVersat minimal controller.
package xtop_pkg;
    localparam int DATA_W      = 32;
    localparam int REGF_ADDR_W = 4;
    localparam int REGF_N      = 1 << REGF_ADDR_W;
    localparam int PROG_ADDR_W = 8;
    localparam int PROG_DEPTH  = 1 << PROG_ADDR_W;
    localparam int INSTR_W     = 16;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LDI   = 4'd1;
    localparam logic [3:0] OP_LDIH  = 4'd2;
    localparam logic [3:0] OP_RDW   = 4'd3;
    localparam logic [3:0] OP_WRW   = 4'd4;
    localparam logic [3:0] OP_RDWB  = 4'd5;
    localparam logic [3:0] OP_WRWB  = 4'd6;
    localparam logic [3:0] OP_ADDI  = 4'd7;
    localparam logic [3:0] OP_ADD   = 4'd8;
    localparam logic [3:0] OP_SUB   = 4'd9;
    localparam logic [3:0] OP_AND   = 4'd10;
    localparam logic [3:0] OP_XOR   = 4'd11;
    localparam logic [3:0] OP_SHFT  = 4'd12;
    localparam logic [3:0] OP_BEQI  = 4'd13;
    localparam logic [3:0] OP_BNEQI = 4'd14;
    localparam logic [3:0] OP_SYS   = 4'd15;

    localparam logic [11:0] TRAP_IMM = 12'hFFF;

    // Whole ROM image; word 0 sits in the least significant slice.
    typedef logic [PROG_DEPTH-1:0][INSTR_W-1:0] prog_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] imm;
    } instr_t;

    function automatic logic [DATA_W-1:0] sext12(input logic [11:0] v);
        return {{(DATA_W-12){v[11]}}, v};
    endfunction
endpackage

// File: rtl/xtop_if.sv
// Host parallel port of the controller: register-file access plus the trap flag.
interface xtop_if;
    import xtop_pkg::*;

    logic [REGF_ADDR_W-1:0] par_addr;
    logic                   par_we;
    logic [DATA_W-1:0]      par_in;
    logic [DATA_W-1:0]      par_out;
    logic                   trap;

    modport master (output par_addr, par_we, par_in, input par_out, trap);
    modport slave  (input par_addr, par_we, par_in, output par_out, trap);
endinterface

// File: rtl/xregf.sv
// 16-entry register file: one CPU and one host write port, three combinational reads.
module xregf
    import xtop_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_we_i,
    input  logic [REGF_ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0]      cpu_data_i,
    input  logic                   host_we_i,
    input  logic [REGF_ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0]      host_data_i,
    input  logic [REGF_ADDR_W-1:0] op_addr_i,
    input  logic [REGF_ADDR_W-1:0] rb_addr_i,
    output logic [DATA_W-1:0]      op_data_o,
    output logic [DATA_W-1:0]      rb_data_o,
    output logic [DATA_W-1:0]      par_out_o
);
    logic [DATA_W-1:0] reg_1 [REGF_N];

    // Host write takes priority when both ports hit the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REGF_N; i++) reg_1[i] <= '0;
        end else begin
            for (int i = 0; i < REGF_N; i++) begin
                if (host_we_i && host_addr_i == REGF_ADDR_W'(i))
                    reg_1[i] <= host_data_i;
                else if (cpu_we_i && cpu_addr_i == REGF_ADDR_W'(i))
                    reg_1[i] <= cpu_data_i;
            end
        end
    end

    assign op_data_o = reg_1[op_addr_i];
    assign rb_data_o = reg_1[rb_addr_i];
    assign par_out_o = reg_1[host_addr_i];
endmodule

// File: rtl/xtop.sv
// picoVersat minimal controller: single-cycle accumulator machine with ROM, register file and trap.
module xtop
    import xtop_pkg::*;
#(
    parameter prog_t PROG_INIT = '0
) (
    input  logic  clk,
    input  logic  rst,
    xtop_if.slave host
);
    logic [PROG_ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0]      ra_q, ra_d;
    logic [REGF_ADDR_W-1:0] rb_q, rb_d;
    logic                   trap_q, trap_d;

    instr_t                 instr;
    logic [DATA_W-1:0]      sx;
    logic [DATA_W-1:0]      r_val;
    logic [DATA_W-1:0]      rbx_val;
    logic                   cpu_we;
    logic [REGF_ADDR_W-1:0] cpu_addr;

    assign instr = instr_t'(PROG_INIT[pc_q]);
    assign sx    = sext12(instr.imm);

    xregf regf (
        .clk         (clk),
        .rst         (rst),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_data_i  (ra_q),
        .host_we_i   (host.par_we),
        .host_addr_i (host.par_addr),
        .host_data_i (host.par_in),
        .op_addr_i   (instr.imm[REGF_ADDR_W-1:0]),
        .rb_addr_i   (rb_q),
        .op_data_o   (r_val),
        .rb_data_o   (rbx_val),
        .par_out_o   (host.par_out)
    );

    always_comb begin
        pc_d     = pc_q + PROG_ADDR_W'(1);
        ra_d     = ra_q;
        rb_d     = rb_q;
        trap_d   = trap_q;
        cpu_we   = 1'b0;
        cpu_addr = instr.imm[REGF_ADDR_W-1:0];

        case (instr.op)
            OP_NOP:   ;
            OP_LDI:   ra_d = sx;
            OP_LDIH:  ra_d = {ra_q[DATA_W-13:0], instr.imm};
            OP_RDW:   ra_d = r_val;
            OP_WRW:   cpu_we = 1'b1;
            OP_RDWB:  ra_d = rbx_val;
            OP_WRWB: begin
                cpu_we   = 1'b1;
                cpu_addr = rb_q;
            end
            OP_ADDI:  ra_d = ra_q + sx;
            OP_ADD:   ra_d = ra_q + r_val;
            OP_SUB:   ra_d = ra_q - r_val;
            OP_AND:   ra_d = ra_q & r_val;
            OP_XOR:   ra_d = ra_q ^ r_val;
            OP_SHFT:  ra_d = instr.imm[0] ? {ra_q[DATA_W-1], ra_q[DATA_W-1:1]}
                                          : {ra_q[DATA_W-2:0], 1'b0};
            OP_BEQI:  if (ra_q == '0) pc_d = instr.imm[PROG_ADDR_W-1:0];
            OP_BNEQI: if (ra_q != '0) pc_d = instr.imm[PROG_ADDR_W-1:0];
            OP_SYS: begin
                if (instr.imm == TRAP_IMM) trap_d = 1'b1;
                else                       rb_d   = ra_q[REGF_ADDR_W-1:0];
            end
        endcase

        // Once trapped the CPU side is frozen; only the host port keeps working.
        if (trap_q) begin
            pc_d   = pc_q;
            ra_d   = ra_q;
            rb_d   = rb_q;
            cpu_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            trap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            trap_q <= trap_d;
        end
    end

    assign host.trap = trap_q;
endmodule

// File: tb/tb_xtop.sv
// Self-checking bench for xtop: four instances running the reference programs side by side.
module tb_xtop;
    import xtop_pkg::*;

    localparam logic [31:0] COLL_VAL = 32'h55AA_1234;

    localparam prog_t P_TRAP = {{((PROG_DEPTH-1)*INSTR_W){1'b0}}, 16'hFFFF};
    localparam prog_t P_ALU  = {{((PROG_DEPTH-9)*INSTR_W){1'b0}},
        16'hFFFF, 16'h4003, 16'hC000, 16'h9001, 16'h4002,
        16'h8001, 16'h1003, 16'h4001, 16'h1005};
    localparam prog_t P_LOOP = {{((PROG_DEPTH-7)*INSTR_W){1'b0}},
        16'hFFFF, 16'hE002, 16'h4000, 16'h7FFF, 16'h3000, 16'h4000, 16'h100A};
    localparam prog_t P_IND  = {{((PROG_DEPTH-6)*INSTR_W){1'b0}},
        16'hFFFF, 16'h6000, 16'h2234, 16'h1001, 16'hF000, 16'h1007};

    logic clk;
    logic rst;

    xtop_if h0 ();
    xtop_if h1 ();
    xtop_if h2 ();
    xtop_if h3 ();

    xtop #(.PROG_INIT(P_TRAP)) u0 (.clk(clk), .rst(rst), .host(h0));
    xtop #(.PROG_INIT(P_ALU))  u1 (.clk(clk), .rst(rst), .host(h1));
    xtop #(.PROG_INIT(P_LOOP)) u2 (.clk(clk), .rst(rst), .host(h2));
    xtop #(.PROG_INIT(P_IND))  u3 (.clk(clk), .rst(rst), .host(h3));

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          te [4];
    logic [31:0] model [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n edges after reset release, recording the edge at which each trap first rises.
    task automatic run(input int n_edges, input bit collide);
        for (int k = 0; k < 4; k++) te[k] = 0;
        for (int e = 1; e <= n_edges; e++) begin
            step();
            if (h0.trap && te[0] == 0) te[0] = e;
            if (h1.trap && te[1] == 0) te[1] = e;
            if (h2.trap && te[2] == 0) te[2] = e;
            if (h3.trap && te[3] == 0) te[3] = e;
            if (collide && e == 7) begin
                h1.par_addr = 4'd3;
                h1.par_in   = COLL_VAL;
                h1.par_we   = 1'b1;
            end
            if (collide && e == 8) h1.par_we = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_trap0"}, 32'(h0.trap), 32'd0);
        chk({tag, "_trap1"}, 32'(h1.trap), 32'd0);
        chk({tag, "_trap2"}, 32'(h2.trap), 32'd0);
        chk({tag, "_trap3"}, 32'(h3.trap), 32'd0);
        for (int i = 0; i < 16; i++) begin
            h0.par_addr = 4'(i);
            h1.par_addr = 4'(i);
            h2.par_addr = 4'(i);
            h3.par_addr = 4'(i);
            #1;
            chk($sformatf("%s_u0_r%0d", tag, i), h0.par_out, 32'd0);
            chk($sformatf("%s_u1_r%0d", tag, i), h1.par_out, 32'd0);
            chk($sformatf("%s_u2_r%0d", tag, i), h2.par_out, 32'd0);
            chk($sformatf("%s_u3_r%0d", tag, i), h3.par_out, 32'd0);
        end
    endtask

    task automatic host1_write(input logic [3:0] a, input logic [31:0] d);
        h1.par_addr = a;
        h1.par_in   = d;
        h1.par_we   = 1'b1;
        step();
        h1.par_we   = 1'b0;
        model[a]    = d;
    endtask

    task automatic sweep_u1(input string tag);
        for (int i = 0; i < 16; i++) begin
            h1.par_addr = 4'(i);
            step();
            chk($sformatf("%s_r%0d", tag, i), h1.par_out, model[i]);
        end
    endtask

    task automatic chk_trap_edges(input string tag);
        chk({tag, "_u0_trap_edge"}, 32'(te[0]), 32'd1);
        chk({tag, "_u1_trap_edge"}, 32'(te[1]), 32'd9);
        chk({tag, "_u2_trap_edge"}, 32'(te[2]), 32'd43);
        chk({tag, "_u3_trap_edge"}, 32'(te[3]), 32'd6);
    endtask

    task automatic chk_other_results(input string tag);
        h2.par_addr = 4'd0;
        h3.par_addr = 4'd7;
        #1;
        chk({tag, "_loop_r0"}, h2.par_out, 32'd0);
        chk({tag, "_ind_r7"}, h3.par_out, 32'h0000_1234);
        h3.par_addr = 4'd0;
        #1;
        chk({tag, "_ind_r0"}, h3.par_out, 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        h0.par_addr = '0; h0.par_we = 1'b0; h0.par_in = '0;
        h1.par_addr = '0; h1.par_we = 1'b0; h1.par_in = '0;
        h2.par_addr = '0; h2.par_we = 1'b0; h2.par_in = '0;
        h3.par_addr = '0; h3.par_we = 1'b0; h3.par_in = '0;

        #3 rst = 1'b0;
        #1;
        chk_reset_state("rst_idle");

        h0.par_addr = 4'd5;
        h0.par_in   = 32'hA5A5_A5A5;
        h0.par_we   = 1'b1;
        step();
        h0.par_we   = 1'b0;
        chk("rst_host_we_ignored", h0.par_out, 32'd0);

        rst = 1'b1;
        #1;
        chk("release_trap0_low", 32'(h0.trap), 32'd0);
        run(60, 1'b0);
        chk_trap_edges("run1");

        for (int i = 0; i < 16; i++) model[i] = '0;
        model[1] = 32'd5;
        model[2] = 32'd8;
        model[3] = 32'd6;
        sweep_u1("alu_dump");
        chk_other_results("run1");

        repeat (5) step();
        chk("trap_sticky", 32'(h1.trap), 32'd1);

        host1_write(4'd4, 32'hDEAD_BEEF);
        h1.par_addr = 4'd4;
        #1;
        chk("host_r4_readback", h1.par_out, 32'hDEAD_BEEF);

        for (int n = 0; n < 24; n++) begin
            logic [3:0] ra;
            if ($urandom_range(0, 1) == 1) host1_write(4'($urandom_range(0, 15)), $urandom);
            ra = 4'($urandom_range(0, 15));
            h1.par_addr = ra;
            #1;
            chk($sformatf("rand_rd%0d_r%0d", n, ra), h1.par_out, model[ra]);
        end
        sweep_u1("post_rand_dump");
        chk("trap_after_host", 32'(h1.trap), 32'd1);

        // Reset after trap, then rerun and interrupt the loop program midway.
        rst = 1'b0;
        #1;
        chk_reset_state("rst_after_trap");
        step();
        rst = 1'b1;
        run(20, 1'b0);
        chk("midrun_loop_no_trap", 32'(h2.trap), 32'd0);
        chk("midrun_alu_trapped", 32'(h1.trap), 32'd1);
        h2.par_addr = 4'd0;
        #1;
        chk("midrun_loop_r0", h2.par_out, 32'd6);
        rst = 1'b0;
        #1;
        chk("midrun_async_r0_clear", h2.par_out, 32'd0);
        chk("midrun_async_trap1_clear", 32'(h1.trap), 32'd0);
        chk_reset_state("midrun_rst");
        step();
        step();
        rst = 1'b1;
        run(60, 1'b1);
        chk_trap_edges("run3");

        for (int i = 0; i < 16; i++) model[i] = '0;
        model[1] = 32'd5;
        model[2] = 32'd8;
        model[3] = COLL_VAL;
        sweep_u1("collide_dump");
        chk_other_results("run3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xtop.md
# xtop

Top level of the picoVersat minimal controller. It is a single-cycle accumulator machine with a program ROM, a 16-entry register file and a trap (halt) flag. A host reads or writes the register file through a parallel port, typically to dump results after `trap` rises. It is the only block the system testbench instantiates.

## Interface
- `DATA_W`, 32: datapath and register width (macro `` `DATA_W `` in `xdefs.vh`)
- `REGF_ADDR_W`, 4: register-file address width, 16 registers (macro `` `REGF_ADDR_W ``)
- `PROG_ADDR_W`, 8: program ROM address width (256 × 16-bit words)
- `PROG_FILE`, "program.hex": ROM image loaded with `$readmemh` at elaboration
- `clk` in 1: clock; all state updates on its rising edge
- `rst` in 1: reset; one clock, asynchronous, active-low
- `trap` out 1: high once a TRAP instruction executes; sticky until reset
- `par_addr` in REGF_ADDR_W: host register address
- `par_we` in 1: host write enable
- `par_in` in DATA_W: host write data
- `par_out` out DATA_W: register-file contents at `par_addr`, combinational

## Operation
- State:
  - `pc` (PROG_ADDR_W)
  - RA accumulator (DATA_W)
  - RB pointer (REGF_ADDR_W)
  - `trap` flag
  - register file r0..r15
- Instruction format: 16 bits; `op`=[15:12], `imm`=[11:0].
- Notation:
  - `sx` = imm sign-extended to DATA_W
  - `R` = regf[imm[3:0]]
  - `RBx` = regf[RB]
- Opcodes (pc+1 unless stated):
  - 0 NOP
  - 1 LDI: RA=sx
  - 2 LDIH: RA={RA[DATA_W-13:0], imm}
  - 3 RDW: RA=R
  - 4 WRW: R=RA
  - 5 RDWB: RA=RBx
  - 6 WRWB: RBx=RA
  - 7 ADDI: RA=RA+sx
  - 8 ADD: RA=RA+R
  - 9 SUB: RA=RA−R
  - 10 AND: RA=RA&R
  - 11 XOR: RA=RA^R
  - 12 SHFT: imm[0]=0 → RA<<1; imm[0]=1 → arithmetic RA>>>1
  - 13 BEQI: pc=imm[PROG_ADDR_W-1:0] if RA==0
  - 14 BNEQI: pc=imm[PROG_ADDR_W-1:0] if RA!=0
  - 15 SYS: imm==12'hFFF → TRAP; otherwise RB=RA[REGF_ADDR_W-1:0]
- Arithmetic is modulo 2^DATA_W with no flags. The pc wraps from 255 to 0.
- TRAP sets `trap`. From the following cycle, `pc`, RA, RB and CPU register writes are frozen.
- The host port stays fully functional after TRAP.
- `par_out` = regf[par_addr] at all times, including during reset.
- Write collision: a host write (`par_we`=1) and a CPU write to the same register in the same cycle → the host value wins.

## Timing
- While `rst`=0: `pc`=0, RA=0, RB=0, `trap`=0, all registers 0. This takes effect immediately and asynchronously. Host writes are ignored during reset.
- The first instruction executes at the first rising edge after `rst` returns high.
- One instruction per cycle. The ROM is read asynchronously at `pc`.
- Writes become visible on `par_out` immediately after the edge.
- A program of N instructions whose last is TRAP raises `trap` at the Nth edge after reset release.
- Register-read latency for the host: 0 cycles (combinational).
- Reset asserted mid-program or after TRAP returns to the reset state and restarts at pc 0.

## Structure
- Shared package/include `xdefs.vh`: `DATA_W`, `REGF_ADDR_W`, opcode constants, the TRAP immediate.
- Sub-module `xregf`, instantiated as `regf`:
  - 16×DATA_W array named `reg_1`, which benches probe hierarchically
  - one CPU write port, one host write port (priority as above)
  - combinational reads for CPU operand, RB-indexed read and `par_out`
- Remaining logic (ROM, pc, decode, ALU, RA/RB, trap) lives in `xtop`.

## Test plan
- Reset/idle: hold `rst`=0 → `trap`=0 and `par_out`=0 for every `par_addr`. Release with ROM = {F FFF} → `trap` rises at the first edge.
- ALU: LDI 5; WRW r1; LDI 3; ADD r1; WRW r2; SUB r1; SHFT 0; WRW r3; TRAP → r2=8, r3=6. TRAP is the 9th instruction, so `trap` rises at the 9th edge after reset release.
- Loop/branch: LDI 10; WRW r0; loop: RDW r0; ADDI −1; WRW r0; BNEQI loop; TRAP → r0=0; 43 cycles to trap.
- Indirect/LDIH: LDI 7; SYS 0 (RB=7); LDI 1; LDIH 0x234; WRWB; TRAP → r7=0x1234.
- Host port:
  - after trap, write r4=0xDEADBEEF via `par_we` → read back 0xDEADBEEF
  - sweep `par_addr` 0..15 one per cycle → values match the expected dump
  - a host write colliding with a CPU WRW to the same register → host value retained
- Reset mid-run: assert `rst`=0 during the loop test → all state clears asynchronously; after release the program reruns from pc 0 with identical results.
